// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM status and RAM access FSM encodings.
// Exports word_t, ramstate_t, ram_acc_state_t and address constants.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACC
  } ram_acc_state_t;

  localparam int WORD_W   = 32;
  localparam int BYTE_OFF = 2;
  localparam int LAT_MAX  = 15;
  localparam int CNT_W    = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: CLK, RST (async high), i_inc, i_clr, o_count[W-1:0].
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ram_access_ctrl.sv
// Turns the RAM request channel into timed single-port SRAM accesses.
// In: CLK, RST, ramREN/ramWEN/ramaddr/ramstore, mem_rdata.
// Out: ramstate, ramload, mem_ren/wen/addr/wdata, rd_count, wr_count.
module ram_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ramREN,
  input  logic              ramWEN,
  input  word_t             ramaddr,
  input  word_t             ramstore,
  output ramstate_t         ramstate,
  output word_t             ramload,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output word_t             mem_wdata,
  input  word_t             mem_rdata,
  output word_t             rd_count,
  output word_t             wr_count
);

  if (LAT < 1 || LAT > LAT_MAX) begin : g_lat_chk
    $fatal(1, "ram_access_ctrl: LAT out of range 1..15");
  end

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LAT - 1);

  ram_acc_state_t     r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wr;
  word_t              r_addr;
  word_t              r_data;

  logic               w_valid;
  logic               w_both;
  logic               w_chg;
  logic               w_rd_fire;
  logic               w_wr_fire;
  logic               w_rd_done;
  logic [ADDR_W-1:0]  w_idx;

  assign w_valid = ramREN ^ ramWEN;
  assign w_both  = ramREN & ramWEN;

  // Any difference from the captured request restarts the wait.
  assign w_chg = (ramWEN != r_wr)
              || (ramaddr != r_addr)
              || (ramstore != r_data);

  assign w_idx = r_addr[ADDR_W+BYTE_OFF-1:BYTE_OFF];

  // Read strobe one cycle ahead of ACC to cover SRAM latency.
  assign w_rd_fire = (r_state == WAIT) && w_valid && !w_chg
                  && (r_cnt == '0) && !r_wr;
  assign w_wr_fire = (r_state == ACC) && r_wr;
  assign w_rd_done = (r_state == ACC) && !r_wr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_wr    <= ramWEN;
            r_addr  <= ramaddr;
            r_data  <= ramstore;
            r_cnt   <= RELOAD;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (!w_valid) begin
            r_state <= IDLE;
          end else if (w_chg) begin
            r_wr   <= ramWEN;
            r_addr <= ramaddr;
            r_data <= ramstore;
            r_cnt  <= RELOAD;
          end else if (r_cnt == '0) begin
            r_state <= ACC;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACC: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ramstate = FREE;
    unique case (r_state)
      IDLE:    ramstate = w_both ? ERROR : FREE;
      WAIT:    ramstate = BUSY;
      ACC:     ramstate = ACCESS;
      default: ramstate = FREE;
    endcase
  end

  assign mem_ren   = w_rd_fire;
  assign mem_wen   = w_wr_fire;
  assign mem_addr  = (w_rd_fire || w_wr_fire) ? w_idx : '0;
  assign mem_wdata = w_wr_fire ? r_data : '0;
  assign ramload   = w_rd_done ? mem_rdata : '0;

  sat_counter #(.W(WORD_W)) u_rd_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .i_inc   (w_rd_done),
    .i_clr   (1'b0),
    .o_count (rd_count)
  );

  sat_counter #(.W(WORD_W)) u_wr_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .i_inc   (w_wr_fire),
    .i_clr   (1'b0),
    .o_count (wr_count)
  );

endmodule
